// File: rtl/roi_sampler_pkg.sv
// roi_sampler_pkg: shared video definitions for the ROI sampler slice.
//   PIX_W / CH_W  : pixel and channel widths ({ch2,ch1,ch0}, 8 b each)
//   state_t       : sampler FSM states
//   sync_edge()   : active-edge detector honouring sync polarity
package roi_sampler_pkg;
    localparam int PIX_W  = 24;
    localparam int CH_W   = 8;
    localparam int NUM_CH = PIX_W / CH_W;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    // cur is the live input, prev its registered copy; pol=1 means active-high.
    function automatic logic sync_edge(input logic cur, input logic prev, input logic pol);
        return pol ? (cur & ~prev) : (~cur & prev);
    endfunction
endpackage

// File: rtl/roi_sampler_if.sv
// roi_sampler_if: pixel-stream bundle for roi_sampler.
//   data_i/vde_i/hsync_i/vsync_i : incoming stream
//   data_o/vde_o/hsync_o/vsync_o : stream delayed 1 cycle, outline applied
//   avg_o/avg_valid_o            : per-channel ROI mean and its update pulse
//   slave  : sampler side,  master : source/sink side
interface roi_sampler_if;
    import roi_sampler_pkg::*;

    logic [PIX_W-1:0] data_i;
    logic             vde_i;
    logic             hsync_i;
    logic             vsync_i;
    logic [PIX_W-1:0] data_o;
    logic             vde_o;
    logic             hsync_o;
    logic             vsync_o;
    logic [PIX_W-1:0] avg_o;
    logic             avg_valid_o;

    modport slave (
        input  data_i, vde_i, hsync_i, vsync_i,
        output data_o, vde_o, hsync_o, vsync_o, avg_o, avg_valid_o
    );
    modport master (
        output data_i, vde_i, hsync_i, vsync_i,
        input  data_o, vde_o, hsync_o, vsync_o, avg_o, avg_valid_o
    );
endinterface

// File: rtl/roi_sampler_chan_acc.sv
// roi_chan_acc: one colour channel of the ROI accumulator.
//   clk, rst_n : pixel clock, async active-low reset
//   clear      : frame boundary, sum restarts (pixel on same cycle still counts)
//   en         : add pixel this cycle
//   load       : capture sum >> (2*ROI_LOG2) into mean (uses pre-clear sum)
//   pixel      : channel value
//   mean       : registered channel mean
module roi_chan_acc
    import roi_sampler_pkg::*;
#(
    parameter int ROI_LOG2 = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en,
    input  logic            load,
    input  logic [CH_W-1:0] pixel,
    output logic [CH_W-1:0] mean
);
    // Sized so a full ROI of 255s just fits.
    localparam int SUM_W = CH_W + 2 * ROI_LOG2;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] addend;

    assign base   = clear ? '0 : sum;
    assign addend = en ? {{(SUM_W-CH_W){1'b0}}, pixel} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            mean <= '0;
        end else begin
            // Top CH_W bits of the sum are exactly sum >> (2*ROI_LOG2).
            if (load)
                mean <= sum[SUM_W-1 -: CH_W];
            if (clear || en)
                sum <= base + addend;
        end
    end
endmodule

// File: rtl/roi_sampler.sv
// roi_sampler: tracks x/y of a pixel stream, sums RGB over a square ROI and reports
// the per-channel mean once per complete frame; passes video through with 1-cycle
// latency and draws the ROI outline in BOX_COLOR.
//   clk, rst_n : pixel clock, async active-low reset
//   vid        : roi_sampler_if.slave (stream in/out, avg_o, avg_valid_o)
module roi_sampler
    import roi_sampler_pkg::*;
#(
    parameter int               H_ACTIVE  = 1280,
    parameter int               V_ACTIVE  = 720,
    parameter int               ROI_X     = 624,
    parameter int               ROI_Y     = 344,
    parameter int               ROI_LOG2  = 5,
    parameter logic [PIX_W-1:0] BOX_COLOR = 24'hFF0000,
    parameter bit               SYNC_POL  = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    roi_sampler_if.slave vid
);
    localparam int SIDE  = 1 << ROI_LOG2;
    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CNT_W = 2 * ROI_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SIDE * SIDE);

    state_t                       state;
    logic [XW-1:0]                x_cnt;
    logic [YW-1:0]                y_cnt;
    logic [YW-1:0]                y_cur;
    logic [CNT_W-1:0]             pix_cnt;
    logic                         vs_edge, vde_fall;
    logic                         in_roi, on_border, acc_en, load;
    logic [NUM_CH-1:0][CH_W-1:0]  mean;

    // The passthrough registers double as the registered copies for edge detection.
    assign vs_edge  = sync_edge(vid.vsync_i, vid.vsync_o, SYNC_POL);
    assign vde_fall = vid.vde_o & ~vid.vde_i;

    // A pixel coinciding with the vsync edge belongs to the new frame (row 0).
    assign y_cur = vs_edge ? '0 : y_cnt;

    assign in_roi = vid.vde_i
                  && int'(x_cnt) >= ROI_X && int'(x_cnt) < ROI_X + SIDE
                  && int'(y_cur) >= ROI_Y && int'(y_cur) < ROI_Y + SIDE;

    assign on_border = in_roi
                     && (int'(x_cnt) == ROI_X || int'(x_cnt) == ROI_X + SIDE - 1
                      || int'(y_cur) == ROI_Y || int'(y_cur) == ROI_Y + SIDE - 1);

    assign acc_en = in_roi && (state == RUN || vs_edge);
    assign load   = vs_edge && state == RUN && pix_cnt == FULL;

    // Position and ROI pixel counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            pix_cnt <= '0;
        end else begin
            if (vid.vde_i)
                x_cnt <= (int'(x_cnt) == H_ACTIVE - 1) ? x_cnt : x_cnt + 1'b1;
            else if (vde_fall)
                x_cnt <= '0;

            if (vs_edge)
                y_cnt <= '0;
            else if (vde_fall && int'(y_cnt) != V_ACTIVE - 1)
                y_cnt <= y_cnt + 1'b1;

            if (vs_edge)
                pix_cnt <= acc_en ? CNT_W'(1) : '0;
            else if (acc_en)
                pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // Frame FSM; the report pulse is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SYNC_WAIT;
            vid.avg_valid_o <= 1'b0;
        end else begin
            vid.avg_valid_o <= load;
            case (state)
                SYNC_WAIT: if (vs_edge) state <= RUN;
                RUN:       state <= RUN;
                default:   state <= SYNC_WAIT;
            endcase
        end
    end

    // Passthrough with outline substitution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.data_o  <= '0;
            vid.vde_o   <= 1'b0;
            vid.hsync_o <= 1'b0;
            vid.vsync_o <= 1'b0;
        end else begin
            vid.data_o  <= on_border ? BOX_COLOR : vid.data_i;
            vid.vde_o   <= vid.vde_i;
            vid.hsync_o <= vid.hsync_i;
            vid.vsync_o <= vid.vsync_i;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        roi_chan_acc #(.ROI_LOG2(ROI_LOG2)) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (vs_edge),
            .en    (acc_en),
            .load  (load),
            .pixel (vid.data_i[c*CH_W +: CH_W]),
            .mean  (mean[c])
        );
    end

    assign vid.avg_o = mean;
endmodule

// File: tb/tb_roi_sampler.sv
// tb_roi_sampler: drives two samplers (active-high and active-low sync) with the
// same randomized frames and checks every output cycle plus every frame report
// against a frame-level model (pixel sums over the ROI, armed-after-vsync rule).
module tb_roi_sampler;
    import roi_sampler_pkg::*;

    localparam int H  = 64;
    localparam int V  = 40;
    localparam int RX = 20;
    localparam int RY = 12;
    localparam int L  = 3;
    localparam int S  = 1 << L;
    localparam logic [23:0] BOX = 24'hFF0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    roi_sampler_if vif1 ();
    roi_sampler_if vif0 ();

    roi_sampler #(.H_ACTIVE(H), .V_ACTIVE(V), .ROI_X(RX), .ROI_Y(RY), .ROI_LOG2(L),
                  .BOX_COLOR(BOX), .SYNC_POL(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n), .vid(vif1));
    roi_sampler #(.H_ACTIVE(H), .V_ACTIVE(V), .ROI_X(RX), .ROI_Y(RY), .ROI_LOG2(L),
                  .BOX_COLOR(BOX), .SYNC_POL(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .vid(vif0));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit          armed;
    int unsigned msum [3];
    int unsigned mcnt;
    logic [23:0] exp_avg;
    int          yy;
    logic [23:0] p_exp;
    logic        p_vde, p_hs, p_vs;
    bit          chk_en;
    int          pc1 = 0;
    int          pc0 = 0;

    always @(negedge clk) begin
        if (vif1.avg_valid_o === 1'b1) pc1++;
        if (vif0.avg_valid_o === 1'b1) pc0++;
    end

    function automatic bit in_roi(input int x, input int y);
        return x >= RX && x < RX + S && y >= RY && y < RY + S;
    endfunction

    function automatic bit on_border(input int x, input int y);
        return in_roi(x, y) && (x == RX || x == RX + S - 1 || y == RY || y == RY + S - 1);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++) msum[c] = 0;
        mcnt = 0;
    endtask

    // One pixel-clock cycle: check the previous cycle's outputs, then apply new inputs.
    task automatic cyc(input logic [23:0] d, input logic de, input logic hs, input logic vs,
                       input logic [23:0] expd);
        @(negedge clk);
        if (chk_en) begin
            chk("data1", 32'(vif1.data_o), 32'(p_exp));
            chk("data0", 32'(vif0.data_o), 32'(p_exp));
            chk("ctl1", 32'({vif1.vde_o, vif1.hsync_o, vif1.vsync_o}), 32'({p_vde, p_hs, p_vs}));
            chk("ctl0", 32'({vif0.vde_o, vif0.hsync_o, vif0.vsync_o}), 32'({p_vde, ~p_hs, ~p_vs}));
        end
        vif1.data_i = d;  vif1.vde_i = de; vif1.hsync_i = hs;  vif1.vsync_i = vs;
        vif0.data_i = d;  vif0.vde_i = de; vif0.hsync_i = ~hs; vif0.vsync_i = ~vs;
        p_exp = expd; p_vde = de; p_hs = hs; p_vs = vs;
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(24'h0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_z1"}, 32'({vif1.data_o, vif1.vde_o, vif1.hsync_o, vif1.vsync_o}), 32'h0);
        chk({tag, "_z0"}, 32'({vif0.data_o, vif0.vde_o, vif0.hsync_o, vif0.vsync_o}), 32'h0);
        chk({tag, "_avg1"}, 32'({vif1.avg_o, vif1.avg_valid_o}), 32'h0);
        chk({tag, "_avg0"}, 32'({vif0.avg_o, vif0.avg_valid_o}), 32'h0);
    endtask

    // Vsync pulse closes the current frame; a report is due only for an armed, full ROI.
    task automatic frame_edge(input string tag);
        int b1, b0;
        bit rep;
        b1 = pc1;
        b0 = pc0;
        rep = armed && mcnt == S * S;
        if (rep)
            exp_avg = {8'(msum[2] / (S * S)), 8'(msum[1] / (S * S)), 8'(msum[0] / (S * S))};
        cyc(24'h0, 1'b0, 1'b0, 1'b1, 24'h0);
        cyc(24'h0, 1'b0, 1'b0, 1'b1, 24'h0);
        idle(3);
        chk({tag, "_pulse1"}, 32'(pc1 - b1), 32'(rep));
        chk({tag, "_pulse0"}, 32'(pc0 - b0), 32'(rep));
        chk({tag, "_avg1"}, 32'(vif1.avg_o), 32'(exp_avg));
        chk({tag, "_avg0"}, 32'(vif0.avg_o), 32'(exp_avg));
        armed = 1'b1;
        model_clear();
        yy = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        armed = 1'b0;
        model_clear();
        exp_avg = 24'h0;
        yy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        p_exp = 24'h0; p_vde = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
    endtask

    // mode 0: uniform 406080, 1: ch0 = x gradient, 2: random
    task automatic line(input int mode);
        logic [23:0] d;
        cyc(24'h0, 1'b0, 1'b1, 1'b0, 24'h0);
        cyc(24'h0, 1'b0, 1'b1, 1'b0, 24'h0);
        idle($urandom_range(1, 3));
        for (int x = 0; x < H; x++) begin
            case (mode)
                0:       d = 24'h406080;
                1:       d = {16'($urandom), 8'(x)};
                default: d = 24'($urandom);
            endcase
            if (armed && in_roi(x, yy)) begin
                msum[0] += d[7:0];
                msum[1] += d[15:8];
                msum[2] += d[23:16];
                mcnt++;
            end
            cyc(d, 1'b1, 1'b0, 1'b0, on_border(x, yy) ? BOX : d);
        end
        idle($urandom_range(1, 3));
        yy++;
    endtask

    task automatic frame(input int mode, input int nlines, input int rst_line);
        for (int l = 0; l < nlines; l++) begin
            if (l == rst_line) do_reset();
            line(mode);
        end
    endtask

    initial begin
        chk_en = 1'b0;
        armed = 1'b0;
        model_clear();
        exp_avg = 24'h0;
        yy = 0;
        vif1.data_i = '0; vif1.vde_i = 1'b0; vif1.hsync_i = 1'b0; vif1.vsync_i = 1'b0;
        vif0.data_i = '0; vif0.vde_i = 1'b0; vif0.hsync_i = 1'b1; vif0.vsync_i = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        p_exp = 24'h0; p_vde = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
        chk_en = 1'b1;
        idle(4);

        frame_edge("first_vs");
        frame(0, V, -1);
        frame_edge("uniform");
        chk("uniform_const", 32'(vif1.avg_o), 32'h406080);

        frame(1, V, -1);
        frame_edge("gradient");
        chk("gradient_ch0", 32'(vif1.avg_o[7:0]), 32'd23);

        frame(2, V, 15);
        frame_edge("after_rst");
        frame(2, V, -1);
        frame_edge("post_rst_full");

        frame(2, 14, -1);
        frame_edge("truncated");
        frame(2, V, -1);
        frame_edge("post_trunc_full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
